// File: rtl/frac_pkg.sv
// ---------------------------------------------------------------------------
// frac_pkg
// Shared definitions for the quarter-pel search sequencer: block geometry,
// motion-vector width, latency-counter width and the controller state
// encoding. Imported by frac_addr_gen and frac_search_ctrl.
// ---------------------------------------------------------------------------
package frac_pkg;

    localparam int FRAC_ROWS  = 8;
    localparam int FRAC_PIX_W = 64;
    localparam int FRAC_MV_W  = 3;
    // Wide enough to hold the largest supported result latency (15).
    localparam int FRAC_LAT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } fracState_t;

endpackage

// File: rtl/frac_addr_gen.sv
// ---------------------------------------------------------------------------
// frac_addr_gen
// Row address generator for one 8x8 block job. On i_load it captures the
// filter/reference base rows and the stride; every i_step cycle both
// addresses advance by the stride (modulo 2^ADDR_W) and the row counter
// increments. o_lastRow flags the cycle that presents the final row.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   i_load                capture bases/stride, restart at row 0
//   i_step                advance to the next row
//   i_filtBase/i_refBase  row-0 addresses of the filter/reference blocks
//   i_stride              address increment between rows
//   o_filtAddr/o_refAddr  current row addresses
//   o_lastRow             current row is row ROWS-1
// ---------------------------------------------------------------------------
module frac_addr_gen
    import frac_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int ROWS   = FRAC_ROWS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_filtBase,
    input  logic [ADDR_W-1:0] i_refBase,
    input  logic [ADDR_W-1:0] i_stride,
    output logic [ADDR_W-1:0] o_filtAddr,
    output logic [ADDR_W-1:0] o_refAddr,
    output logic              o_lastRow
);

    localparam int CNT_W = $clog2(ROWS);

    logic [CNT_W-1:0]  r_rowCnt;
    logic [ADDR_W-1:0] r_filtAddr;
    logic [ADDR_W-1:0] r_refAddr;
    logic [ADDR_W-1:0] r_stride;

    // Addresses are accumulated rather than multiplied; natural wrap of the
    // ADDR_W-bit adders gives the modulo behaviour the buffer expects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rowCnt   <= '0;
            r_filtAddr <= '0;
            r_refAddr  <= '0;
            r_stride   <= '0;
        end else if (i_load) begin
            r_rowCnt   <= '0;
            r_filtAddr <= i_filtBase;
            r_refAddr  <= i_refBase;
            r_stride   <= i_stride;
        end else if (i_step) begin
            r_rowCnt   <= r_rowCnt + CNT_W'(1);
            r_filtAddr <= r_filtAddr + r_stride;
            r_refAddr  <= r_refAddr + r_stride;
        end
    end

    assign o_filtAddr = r_filtAddr;
    assign o_refAddr  = r_refAddr;
    assign o_lastRow  = (r_rowCnt == CNT_W'(ROWS - 1));

endmodule

// File: rtl/frac_search_ctrl.sv
// ---------------------------------------------------------------------------
// frac_search_ctrl
// Sequencer for the 8x8 quarter-pel search engine. Accepts one block job,
// issues ROWS row reads to the dual-port block buffer, streams the returned
// rows to the engine framed by eng_input_ready, waits RES_LAT cycles for the
// engine to settle, then captures the motion vector and holds it on a
// valid/ready result port.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req_valid/req_ready        job handshake
//   req_filt_base/req_ref_base row-0 addresses, req_stride row increment
//   mem_rd_en, mem_*_addr      block-buffer read request (both ports)
//   mem_*_data                 returned rows, one cycle after mem_rd_en
//   eng_*_pix, eng_input_ready row stream to the engine
//   eng_mvx/eng_mvy            engine motion vector (signed)
//   res_valid/res_ready        result handshake, res_mvx/res_mvy payload
//   busy                       controller is not idle
// ---------------------------------------------------------------------------
module frac_search_ctrl
    import frac_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int PIX_W   = FRAC_PIX_W,
    parameter int ROWS    = FRAC_ROWS,
    parameter int RES_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_filt_base,
    input  logic [ADDR_W-1:0]    req_ref_base,
    input  logic [ADDR_W-1:0]    req_stride,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_filt_addr,
    output logic [ADDR_W-1:0]    mem_ref_addr,
    input  logic [PIX_W-1:0]     mem_filt_data,
    input  logic [PIX_W-1:0]     mem_ref_data,
    output logic [PIX_W-1:0]     eng_filter_pix,
    output logic [PIX_W-1:0]     eng_ref_pix,
    output logic                 eng_input_ready,
    input  logic [FRAC_MV_W-1:0] eng_mvx,
    input  logic [FRAC_MV_W-1:0] eng_mvy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [FRAC_MV_W-1:0] res_mvx,
    output logic [FRAC_MV_W-1:0] res_mvy,
    output logic                 busy
);

    fracState_t r_state;
    fracState_t w_nextState;

    logic [FRAC_LAT_W-1:0] r_latCnt;
    logic                  r_inputReady;
    logic [FRAC_MV_W-1:0]  r_resMvx;
    logic [FRAC_MV_W-1:0]  r_resMvy;

    logic w_accept;
    logic w_lastRow;
    logic w_capture;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_capture = (r_state == ST_WAIT) && (r_latCnt == FRAC_LAT_W'(1));

    frac_addr_gen #(
        .ADDR_W (ADDR_W),
        .ROWS   (ROWS)
    ) u_addrGen (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_step     (r_state == ST_FETCH),
        .i_filtBase (req_filt_base),
        .i_refBase  (req_ref_base),
        .i_stride   (req_stride),
        .o_filtAddr (mem_filt_addr),
        .o_refAddr  (mem_ref_addr),
        .o_lastRow  (w_lastRow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. WAIT leaves on the cycle the engine outputs are
    // valid, which is the same cycle the result registers capture them.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid)             w_nextState = ST_FETCH;
            ST_FETCH: if (w_lastRow)             w_nextState = ST_DRAIN;
            ST_DRAIN:                            w_nextState = ST_WAIT;
            ST_WAIT:  if (w_capture)             w_nextState = ST_HOLD;
            ST_HOLD:  if (res_ready)             w_nextState = ST_IDLE;
            default:                             w_nextState = ST_IDLE;
        endcase
    end

    // Output decode. res_valid is a pure state decode so it drops the cycle
    // after the handshake and a new job waits for IDLE.
    always_comb begin
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_FETCH: mem_rd_en = 1'b1;
            ST_HOLD:  res_valid = 1'b1;
            default:  ;
        endcase
    end

    // Framing follows the read strobe by the buffer's one-cycle latency, and
    // the latency counter is loaded in DRAIN so that count==1 marks the cycle
    // RES_LAT after the last framed row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inputReady <= 1'b0;
            r_latCnt     <= '0;
            r_resMvx     <= '0;
            r_resMvy     <= '0;
        end else begin
            r_inputReady <= mem_rd_en;
            if (r_state == ST_DRAIN) begin
                r_latCnt <= FRAC_LAT_W'(RES_LAT);
            end else if (r_state == ST_WAIT) begin
                r_latCnt <= r_latCnt - FRAC_LAT_W'(1);
            end
            if (w_capture) begin
                r_resMvx <= eng_mvx;
                r_resMvy <= eng_mvy;
            end
        end
    end

    assign eng_input_ready = r_inputReady;
    assign eng_filter_pix  = mem_filt_data;
    assign eng_ref_pix     = mem_ref_data;
    assign res_mvx         = r_resMvx;
    assign res_mvy         = r_resMvy;

endmodule

// File: tb/tb_frac_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frac_search_ctrl
// Scoreboard bench for frac_search_ctrl. Stimulus pushes the expected row
// addresses, engine pixel rows and result (mv plus the cycle res_valid must
// rise) into queues; monitor processes pop and compare whenever the DUT
// strobes a read, frames a row or presents a result. A second instance with
// RES_LAT=15 shares the inputs and is used for the long-latency capture.
// ---------------------------------------------------------------------------
module tb_frac_search_ctrl;

    localparam int LAT_A = 3;
    localparam int LAT_B = 15;

    typedef struct { logic [9:0] f; logic [9:0] r; } addrPair_t;
    typedef struct { logic [63:0] f; logic [63:0] r; } pixPair_t;
    typedef struct { logic [2:0] mx; logic [2:0] my; int rise; } result_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_filt_base = '0;
    logic [9:0]  req_ref_base = '0;
    logic [9:0]  req_stride = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_filt_addr, mem_ref_addr;
    logic [63:0] mem_filt_data = '0;
    logic [63:0] mem_ref_data = '0;
    logic [63:0] eng_filter_pix, eng_ref_pix;
    logic        eng_input_ready;
    logic [2:0]  eng_mvx = '0;
    logic [2:0]  eng_mvy = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [2:0]  res_mvx, res_mvy;
    logic        busy;

    logic        reqReadyB, memRdEnB, inputReadyB, resValidB, busyB;
    logic [9:0]  filtAddrB, refAddrB;
    logic [63:0] filtPixB, refPixB;
    logic [2:0]  resMvxB, resMvyB;

    int checks = 0;
    int failures = 0;
    int cycleCnt = 0;
    logic prevResValid = 1'b0;

    addrPair_t qAddr[$];
    pixPair_t  qPix[$];
    result_t   qRes[$];

    frac_search_ctrl #(.ADDR_W(10), .PIX_W(64), .ROWS(8), .RES_LAT(LAT_A)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_filt_base(req_filt_base), .req_ref_base(req_ref_base), .req_stride(req_stride),
        .mem_rd_en(mem_rd_en), .mem_filt_addr(mem_filt_addr), .mem_ref_addr(mem_ref_addr),
        .mem_filt_data(mem_filt_data), .mem_ref_data(mem_ref_data),
        .eng_filter_pix(eng_filter_pix), .eng_ref_pix(eng_ref_pix), .eng_input_ready(eng_input_ready),
        .eng_mvx(eng_mvx), .eng_mvy(eng_mvy),
        .res_valid(res_valid), .res_ready(res_ready), .res_mvx(res_mvx), .res_mvy(res_mvy),
        .busy(busy)
    );

    frac_search_ctrl #(.ADDR_W(10), .PIX_W(64), .ROWS(8), .RES_LAT(LAT_B)) dutLong (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(reqReadyB),
        .req_filt_base(req_filt_base), .req_ref_base(req_ref_base), .req_stride(req_stride),
        .mem_rd_en(memRdEnB), .mem_filt_addr(filtAddrB), .mem_ref_addr(refAddrB),
        .mem_filt_data(mem_filt_data), .mem_ref_data(mem_ref_data),
        .eng_filter_pix(filtPixB), .eng_ref_pix(refPixB), .eng_input_ready(inputReadyB),
        .eng_mvx(eng_mvx), .eng_mvy(eng_mvy),
        .res_valid(resValidB), .res_ready(res_ready), .res_mvx(resMvxB), .res_mvy(resMvyB),
        .busy(busyB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [63:0] patF(input logic [9:0] a);
        return {16'hF11F, 6'd0, a, 22'd0, a};
    endfunction

    function automatic logic [63:0] patR(input logic [9:0] a);
        return {16'h7EF0, 6'd0, ~a, 22'd0, a};
    endfunction

    // Block buffer model: one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_filt_data <= patF(mem_filt_addr);
            mem_ref_data  <= patR(mem_ref_addr);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cycleCnt);
        end
    endtask

    task automatic pushJob(input logic [9:0] f, input logic [9:0] r, input logic [9:0] s,
                           input logic [2:0] mx, input logic [2:0] my, input int t0);
        addrPair_t a;
        pixPair_t  p;
        result_t   e;
        for (int k = 0; k < 8; k++) begin
            a.f = 10'(int'(f) + k * int'(s));
            a.r = 10'(int'(r) + k * int'(s));
            p.f = patF(a.f);
            p.r = patR(a.r);
            qAddr.push_back(a);
            qPix.push_back(p);
        end
        e.mx = mx;
        e.my = my;
        e.rise = t0 + 10 + LAT_A;
        qRes.push_back(e);
    endtask

    // Issues one job pulse, records the accept cycle t0, and returns just
    // after the accepting edge with req_valid dropped.
    task automatic applyStimulus(input logic [9:0] f, input logic [9:0] r, input logic [9:0] s,
                                 input logic [2:0] mx, input logic [2:0] my, output int t0);
        int guard = 0;
        t0 = 0;
        @(posedge clk); #1;
        req_filt_base = f;
        req_ref_base  = r;
        req_stride    = s;
        eng_mvx       = mx;
        eng_mvy       = my;
        req_valid     = 1'b1;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checkOutput("acceptTimeout", req_ready, 1'b1);
        end else begin
            t0 = cycleCnt;
            pushJob(f, r, s, mx, my, t0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge clk);
        while ((qRes.size() != 0 || !req_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (qRes.size() != 0 || !req_ready)
            checkOutput("idleTimeout", {63'd0, req_ready && (qRes.size() == 0)}, 64'd1);
        checkOutput("leftoverAddr", qAddr.size(), 0);
        checkOutput("leftoverPix", qPix.size(), 0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstRdEn", mem_rd_en, 1'b0);
        checkOutput("rstInputReady", eng_input_ready, 1'b0);
        checkOutput("rstResValid", res_valid, 1'b0);
        checkOutput("rstMvx", res_mvx, 3'd0);
        checkOutput("rstMvy", res_mvy, 3'd0);
        checkOutput("rstFiltAddr", mem_filt_addr, 10'd0);
        checkOutput("rstRefAddr", mem_ref_addr, 10'd0);
        checkOutput("rstBusy", busy, 1'b0);
    endtask

    // Read-address monitor.
    always @(negedge clk) begin : monAddr
        addrPair_t ea;
        if (mem_rd_en) begin
            if (qAddr.size() == 0) begin
                checkOutput("unexpectedRead", mem_rd_en, 1'b0);
            end else begin
                ea = qAddr.pop_front();
                checkOutput("filtAddr", mem_filt_addr, ea.f);
                checkOutput("refAddr", mem_ref_addr, ea.r);
            end
        end
    end

    // Engine row-stream monitor.
    always @(negedge clk) begin : monPix
        pixPair_t ep;
        if (eng_input_ready) begin
            if (qPix.size() == 0) begin
                checkOutput("unexpectedInputReady", eng_input_ready, 1'b0);
            end else begin
                ep = qPix.pop_front();
                checkOutput("filterPix", eng_filter_pix, ep.f);
                checkOutput("refPix", eng_ref_pix, ep.r);
            end
        end
    end

    // Result monitor: rise timing on the first valid cycle, payload at the
    // handshake.
    always @(negedge clk) begin : monRes
        result_t er;
        if (res_valid && !prevResValid) begin
            if (qRes.size() == 0)
                checkOutput("unexpectedResult", res_valid, 1'b0);
            else
                checkOutput("resRiseCycle", cycleCnt, qRes[0].rise);
        end
        if (res_valid && res_ready && qRes.size() != 0) begin
            er = qRes.pop_front();
            checkOutput("resMvx", res_mvx, er.mx);
            checkOutput("resMvy", res_mvy, er.my);
        end
        prevResValid = res_valid;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int t0;
        int guard;

        // Power-on reset.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetOutputs();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reqReadyAfterReset", req_ready, 1'b1);

        // Basic job: unit stride, mvx=-1, mvy=1.
        applyStimulus(10'h010, 10'h100, 10'd1, 3'b111, 3'b001, t0);
        waitIdle();

        // Reset in the middle of a fetch discards the job.
        applyStimulus(10'h040, 10'h080, 10'd1, 3'b010, 3'b010, t0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        qAddr.delete();
        qPix.delete();
        qRes.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkResetOutputs();
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reqReadyAfterMidReset", req_ready, 1'b1);
        checkOutput("busyAfterMidReset", busy, 1'b0);
        repeat (30) @(negedge clk);

        // Stride 2 with address wrap on both ports.
        applyStimulus(10'h3FC, 10'h3FF, 10'd2, 3'b011, 3'b100, t0);
        waitIdle();

        // Zero stride: same row eight times.
        applyStimulus(10'h155, 10'h2AA, 10'd0, 3'b000, 3'b111, t0);
        waitIdle();

        // Backpressure: result held, new requests ignored.
        res_ready = 1'b0;
        applyStimulus(10'h020, 10'h220, 10'd3, 3'b101, 3'b010, t0);
        guard = 0;
        @(negedge clk);
        while (!res_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bpResValidSeen", res_valid, 1'b1);
        @(posedge clk); #1;
        eng_mvx = 3'b000;
        eng_mvy = 3'b000;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                req_filt_base = 10'h111;
                req_valid = 1'b1;
            end
            if (i == 6) req_valid = 1'b0;
            @(negedge clk);
            checkOutput("bpResValid", res_valid, 1'b1);
            checkOutput("bpMvx", res_mvx, 3'b101);
            checkOutput("bpMvy", res_mvy, 3'b010);
            checkOutput("bpReqReady", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reqReadyAfterHs", req_ready, 1'b1);
        checkOutput("resValidAfterHs", res_valid, 1'b0);
        waitIdle();

        // Back-to-back: req_valid held, one accept every 11+LAT_A cycles.
        eng_mvx = 3'b110;
        eng_mvy = 3'b011;
        @(posedge clk); #1;
        req_filt_base = 10'h300;
        req_ref_base  = 10'h000;
        req_stride    = 10'd5;
        req_valid     = 1'b1;
        @(negedge clk);
        t0 = cycleCnt;
        for (int j = 0; j < 3; j++)
            pushJob(10'h300, 10'h000, 10'd5, 3'b110, 3'b011, t0 + j * (11 + LAT_A));
        for (int off = 0; off <= 2 * (11 + LAT_A); off++) begin
            if (off > 0) @(negedge clk);
            checkOutput("b2bReqReady", req_ready, (off % (11 + LAT_A)) == 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitIdle();

        // Latency: both instances take the same job; eng_mvx carries a
        // distinct value on each capture cycle and different values on the
        // neighbouring cycles.
        guard = 0;
        while (busyB && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("longIdle", busyB, 1'b0);
        applyStimulus(10'h0A0, 10'h1B0, 10'd4, 3'b010, 3'b111, t0);
        for (int off = 1; off <= 26; off++) begin
            case (off)
                9 + LAT_A - 1: eng_mvx = 3'b100;
                9 + LAT_A:     eng_mvx = 3'b010;
                9 + LAT_A + 1: eng_mvx = 3'b101;
                9 + LAT_B - 1: eng_mvx = 3'b100;
                9 + LAT_B:     eng_mvx = 3'b011;
                9 + LAT_B + 1: eng_mvx = 3'b101;
                default:       eng_mvx = 3'b110;
            endcase
            @(negedge clk);
            if (off == 1) checkOutput("longBusy", busyB, 1'b1);
            if (off == 9 + LAT_B) checkOutput("longEarlyValid", resValidB, 1'b0);
            if (off == 10 + LAT_B) begin
                checkOutput("longResValid", resValidB, 1'b1);
                checkOutput("longMvx", resMvxB, 3'b011);
                checkOutput("longMvy", resMvyB, 3'b111);
            end
            @(posedge clk); #1;
        end
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
